// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator / checker pair.
//   lfsr_state_e   : checker synchronisation states
//   LFSR_WIDTH_DEF : default LFSR length
//   lfsr_fb()      : feedback bit of a Fibonacci LFSR, ^(tap & state)
package lfsr_pkg;

  localparam int LFSR_WIDTH_DEF = 8;
  // Widest LFSR the feedback helper supports; narrower operands are zero-extended.
  localparam int LFSR_MAX_W     = 32;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] tap,
                                   input logic [LFSR_MAX_W-1:0] state);
    return ^(tap & state);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between a PRBS source/monitor and lfsr_checker.
//   tap       : feedback tap mask            (master -> slave)
//   din_valid : din carries a stream bit     (master -> slave)
//   din       : received stream bit          (master -> slave)
//   clr_err   : synchronous error-count clear(master -> slave)
//   locked    : checker synchronised         (slave -> master)
//   err_pulse : one-cycle strobe per error   (slave -> master)
//   err_count : saturating error count       (slave -> master)
interface lfsr_checker_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = LFSR_WIDTH_DEF,
  parameter int ERR_CNT_W = 16
);

  logic [WIDTH-1:0]     tap;
  logic                 din_valid;
  logic                 din;
  logic                 clr_err;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output tap, din_valid, din, clr_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  tap, din_valid, din, clr_err,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/lfsr_err_counter.sv
// Saturating, clearable error counter.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one error this cycle
//   clr        : clear the count; a simultaneous inc leaves the count at 1
//   count      : current count, holds at all-ones
module lfsr_err_counter #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] count
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      // The error arriving with the clear is the first one of the new count.
      count <= inc ? ERR_CNT_W'(1) : '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the configurable Fibonacci LFSR generator.
// Fills its history from the stream, hunts for LOCK_COUNT consecutive correct
// predictions, then free-runs on its own predictions and counts bit errors.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lfsr_checker_if.slave (tap, din_valid, din, clr_err in;
//                locked, err_pulse, err_count out)
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH       = LFSR_WIDTH_DEF,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_ERRS - 1);

  lfsr_state_e          state_q, state_d;
  logic [WIDTH-1:0]     tap_r;
  logic [WIDTH-1:0]     hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MATCH_W-1:0]   run_q, run_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_d;
  logic                 pred;
  logic                 tap_chg;
  logic [ERR_CNT_W-1:0] err_count_w;

  assign tap_chg = (bus.tap != tap_r);
  assign pred    = lfsr_fb(LFSR_MAX_W'(tap_r), LFSR_MAX_W'(hist_q));

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    run_d    = run_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    err_d    = 1'b0;

    if (tap_chg) begin
      // Restart on a new polynomial. A valid bit in this cycle is kept as the
      // first fill bit, so the first bit after reset release is never lost.
      state_d  = FILL;
      locked_d = 1'b0;
      match_d  = '0;
      run_d    = '0;
      miss_d   = '0;
      fill_d   = '0;
      if (bus.din_valid) begin
        hist_d = {hist_q[WIDTH-2:0], bus.din};
        fill_d = FILL_W'(1);
      end
    end else if (bus.din_valid) begin
      unique case (state_q)
        FILL: begin
          hist_d = {hist_q[WIDTH-2:0], bus.din};
          if (fill_q >= FILL_LAST) begin
            fill_d = FILL_FULL;
            // A zero tap mask can never predict anything: park in FILL.
            if (tap_r != '0) begin
              state_d = HUNT;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        HUNT: begin
          // Self-synchronising: the received bit always enters the history.
          hist_d = {hist_q[WIDTH-2:0], bus.din};
          if ((bus.din == pred) && (hist_q != '0)) begin
            if (match_q == MATCH_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
              run_d    = '0;
              miss_d   = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          // Free-run on the prediction so one line error stays one error.
          hist_d = {hist_q[WIDTH-2:0], pred};
          if (bus.din != pred) begin
            err_d = 1'b1;
            run_d = '0;
            if (miss_q == MISS_LAST) begin
              state_d  = FILL;
              locked_d = 1'b0;
              fill_d   = '0;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else if (run_q == MATCH_LAST) begin
            // A long enough clean run forgives earlier isolated errors.
            run_d  = '0;
            miss_d = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end

        default: begin
          state_d  = FILL;
          locked_d = 1'b0;
          fill_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      tap_r       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_r       <= bus.tap;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_d;
    end
  end

  lfsr_err_counter #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (err_d),
    .clr   (bus.clr_err),
    .count (err_count_w)
  );

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_w;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the configurable 8-bit Fibonacci LFSR pattern generator. It self-synchronises to an incoming one-bit PRBS stream generated with a runtime-selectable tap mask, declares lock, then counts bit errors. It sits at the sink end of a BIST/link-test path, opposite the LFSR generator.

## Interface
- WIDTH, 8: LFSR length and tap/history width.
- LOCK_COUNT, 16: consecutive correct predictions required to declare lock.
- UNLOCK_ERRS, 4: mismatches while locked (without an intervening clean run) that drop lock.
- ERR_CNT_W, 16: error counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- tap  in  WIDTH  feedback tap mask, same meaning as the generator's.
- din_valid  in  1  din carries a stream bit this cycle.
- din  in  1  received stream bit.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle strobe per detected bit error while locked.
- err_count  out  ERR_CNT_W  saturating count of errors while locked.

## Operation
- Stream model: generator state s, next bit b = ^(tap & s), s <= {s[WIDTH-2:0], b}; the stream is the sequence of b. The checker keeps history h (h[0] = newest bit) and predicts p = ^(tap_r & h).
- tap_r: register loaded from tap every cycle. When tap != tap_r, force state FILL and clear the fill counter and match counter.
- States (package enum): FILL, HUNT, LOCKED. Reset state is FILL. Only cycles with din_valid=1 advance anything except tap-change and clr_err.
- FILL: h <= {h[WIDTH-2:0], din}, fill_cnt++. After WIDTH valid bits, go to HUNT. If tap_r == 0, stay in FILL (degenerate).
- HUNT: h <= {h, din} (received bit, self-sync). If din == p and h != 0, match_cnt++. Otherwise match_cnt <= 0; all-zero history never counts. When the LOCK_COUNT-th match is processed, go to LOCKED, set locked, clear miss_cnt.
- LOCKED: h <= {h, p} (free-running on prediction, so there is no error multiplication).
  - din != p: err_pulse=1, err_count++ (saturating at all-ones), miss_cnt++, run_cnt <= 0.
  - din == p: run_cnt++; when run_cnt reaches LOCK_COUNT, miss_cnt <= 0.
  - When miss_cnt reaches UNLOCK_ERRS: go to FILL, locked <= 0, fill_cnt <= 0.
- clr_err: err_count <= 0. If clr_err coincides with an error, err_count <= 1.
- err_count holds its value across lock loss; only reset or clr_err clears it.

## Timing
- All outputs registered. Reset values: locked=0, err_pulse=0, err_count=0; h, tap_r and all counters are 0.
- din is sampled at the rising edge where din_valid=1. err_pulse, err_count and locked reflect that bit starting the following cycle.
- Lock latency from reset or restart: WIDTH + LOCK_COUNT valid bits of a clean stream (24 with defaults). Gaps in din_valid stretch the latency but do not change the bit count.
- A tap change while locked: locked=0 the cycle after tap_r updates. There is no error pulse for the transition bit.
- Async reset mid-operation returns to FILL immediately. The first valid bit after reset release is bit 0 of the fill.

## Structure
- Package lfsr_pkg holds:
  - the state enum typedef {FILL, HUNT, LOCKED};
  - the default WIDTH constant;
  - a function lfsr_fb(tap, state) returning ^(tap & state), shared with the generator.
- One natural sub-module: lfsr_err_counter. It is a saturating, clearable counter of ERR_CNT_W bits with inc/clr inputs and the clr+inc → 1 rule.
- The FSM, history register and match/run/miss counters live in lfsr_checker.

## Test plan
- Clean lock and run:
  - Stimulus: tap=8'hB8, generator seed 8'h01, din_valid=1 every cycle, 1000 bits.
  - Required: locked rises after the 24th bit, err_count=0, err_pulse never asserted.
- Single error while locked:
  - Stimulus: invert one bit.
  - Required: exactly one err_pulse, err_count=1, locked stays 1, no follow-on errors.
- Burst error and relock:
  - Stimulus: invert 4 bits within 10.
  - Required: locked=0 after the 4th error, err_count=4, locked=1 again 24 valid bits later.
- Degenerate inputs:
  - Stimulus: all-zero stream with tap=8'hB8.
  - Required: locked never asserts.
  - Stimulus: tap=8'h00 with any stream.
  - Required: the checker stays in FILL.
- Valid gaps and tap change:
  - Stimulus: din_valid once every 3 cycles.
  - Required: lock on the 24th valid bit.
  - Stimulus: change tap to 8'h8E while locked.
  - Required: locked=0 next cycle, then relock on the new stream.
- Counter rules:
  - Stimulus: ERR_CNT_W=4 with 20 errors.
  - Required: err_count holds at 15.
  - Stimulus: clr_err in the same cycle as an error.
  - Required: err_count=1.
  - Stimulus: assert reset mid-stream.
  - Required: all outputs return to 0 immediately.
